// File: rtl/vocab_scan_ctrl.sv
// Vocabulary lookup sequencer: streams the vocab SRAM entry by entry and compares each
// entry against a latched query word, reporting presence and base address.
module vocab_scan_ctrl #(
    parameter int unsigned ADDR_WIDTH  = 4,
    parameter int unsigned WORD_LENGTH = 3,
    parameter int unsigned DATA_WIDTH  = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [WORD_LENGTH*DATA_WIDTH-1:0] word,
    output logic                              busy,
    output logic                              done,
    output logic                              found,
    output logic [ADDR_WIDTH-1:0]             match_idx,
    output logic                              mem_cs,
    output logic [ADDR_WIDTH-1:0]             mem_addr,
    input  logic [DATA_WIDTH-1:0]             mem_dout
);

    localparam int unsigned NumEntries = (2 ** ADDR_WIDTH) / WORD_LENGTH;
    localparam int unsigned PtrW       = ADDR_WIDTH + 1;
    localparam int unsigned ChrW       = (WORD_LENGTH > 1) ? $clog2(WORD_LENGTH) : 1;

    localparam logic [PtrW-1:0] EndPtr   = PtrW'(NumEntries * WORD_LENGTH);
    localparam logic [PtrW-1:0] LastBase = PtrW'((NumEntries - 1) * WORD_LENGTH);
    localparam logic [PtrW-1:0] WordStep = PtrW'(WORD_LENGTH);
    localparam logic [ChrW-1:0] LastChr  = ChrW'(WORD_LENGTH - 1);

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   chars_q [WORD_LENGTH];
    logic                    load_word;
    logic [PtrW-1:0]         ptr_q, ptr_d;
    logic [ChrW-1:0]         chr_q, chr_d;
    logic [PtrW-1:0]         base_q, base_d;
    // Tag travelling one cycle behind each read, aligned with mem_dout.
    logic                    rd_vld_q, rd_vld_d;
    logic [ChrW-1:0]         rd_chr_q, rd_chr_d;
    logic [PtrW-1:0]         rd_base_q, rd_base_d;
    logic                    mis_q, mis_d;
    logic                    found_q, found_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic                    issue;
    logic                    mis_now;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        chr_d     = chr_q;
        base_d    = base_q;
        rd_vld_d  = 1'b0;
        rd_chr_d  = rd_chr_q;
        rd_base_d = rd_base_q;
        mis_d     = mis_q;
        found_d   = found_q;
        idx_d     = idx_q;
        load_word = 1'b0;
        mem_cs    = 1'b0;
        mem_addr  = '0;
        issue     = 1'b0;
        mis_now   = mis_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StScan;
                    load_word = 1'b1;
                    ptr_d     = '0;
                    chr_d     = '0;
                    base_d    = '0;
                    mis_d     = 1'b0;
                    found_d   = 1'b0;
                    idx_d     = '0;
                end
            end
            StScan: begin
                issue = (ptr_q != EndPtr);
                if (issue) begin
                    mem_cs   = 1'b1;
                    mem_addr = ptr_q[ADDR_WIDTH-1:0];
                    ptr_d    = ptr_q + 1'b1;
                    if (chr_q == LastChr) begin
                        chr_d  = '0;
                        base_d = base_q + WordStep;
                    end else begin
                        chr_d = chr_q + 1'b1;
                    end
                end
                rd_vld_d  = issue;
                rd_chr_d  = chr_q;
                rd_base_d = base_q;

                if (rd_vld_q) begin
                    // char 0 starts a fresh entry, so it overwrites the mismatch flag
                    if (rd_chr_q == '0) begin
                        mis_now = (mem_dout != chars_q[rd_chr_q]);
                    end else begin
                        mis_now = mis_q | (mem_dout != chars_q[rd_chr_q]);
                    end
                    mis_d = mis_now;
                    if ((rd_chr_q == '0) && (mem_dout == '0)) begin
                        state_d = StDone;
                    end else if (rd_chr_q == LastChr) begin
                        if (!mis_now) begin
                            state_d = StDone;
                            found_d = 1'b1;
                            idx_d   = rd_base_q[ADDR_WIDTH-1:0];
                        end else if (rd_base_q == LastBase) begin
                            state_d = StDone;
                        end
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            chr_q     <= '0;
            base_q    <= '0;
            rd_vld_q  <= 1'b0;
            rd_chr_q  <= '0;
            rd_base_q <= '0;
            mis_q     <= 1'b0;
            found_q   <= 1'b0;
            idx_q     <= '0;
            for (int i = 0; i < WORD_LENGTH; i++) begin
                chars_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            chr_q     <= chr_d;
            base_q    <= base_d;
            rd_vld_q  <= rd_vld_d;
            rd_chr_q  <= rd_chr_d;
            rd_base_q <= rd_base_d;
            mis_q     <= mis_d;
            found_q   <= found_d;
            idx_q     <= idx_d;
            if (load_word) begin
                for (int i = 0; i < WORD_LENGTH; i++) begin
                    chars_q[i] <= word[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign found     = found_q;
    assign match_idx = idx_q;

endmodule

// File: tb/tb_vocab_scan_ctrl.sv
// Scoreboard bench for vocab_scan_ctrl: directed lookups against a behavioural SRAM,
// with a monitor checking result, done cycle and address range at every done pulse.
module tb_vocab_scan_ctrl;

    localparam int AW = 4;
    localparam int W  = 3;
    localparam int DW = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [W*DW-1:0]   word;
    logic              busy, done, found, mem_cs;
    logic [AW-1:0]     match_idx, mem_addr;
    logic [DW-1:0]     mem_dout;
    logic [DW-1:0]     mem [16];

    int tests    = 0;
    int fails    = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int max_addr = -1;

    typedef struct {
        logic          found;
        logic [AW-1:0] idx;
        int            cyc;
        int            min_a;
        int            max_a;
    } exp_t;
    exp_t sb[$];

    vocab_scan_ctrl #(.ADDR_WIDTH(AW), .WORD_LENGTH(W), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .word      (word),
        .busy      (busy),
        .done      (done),
        .found     (found),
        .match_idx (match_idx),
        .mem_cs    (mem_cs),
        .mem_addr  (mem_addr),
        .mem_dout  (mem_dout)
    );

    always #5 clk = ~clk;

    // SRAM model: data one cycle after the address.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_cs) mem_dout <= mem[mem_addr];
    end

    task automatic chk(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: pops an expectation on every done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            max_addr = -1;
        end else begin
            if (mem_cs && int'(mem_addr) > max_addr) max_addr = int'(mem_addr);
            if (done) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL spurious_done: done at cycle %0d, expected none", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("found", int'(found), int'(e.found));
                    chk("match_idx", int'(match_idx), int'(e.idx));
                    chk("done_cycle", cyc, e.cyc);
                    chk("busy_at_done", int'(busy), 1);
                    chk("max_addr_lo", (max_addr >= e.min_a) ? 1 : 0, 1);
                    chk("max_addr_hi", (max_addr <= e.max_a) ? 1 : 0, 1);
                end
                max_addr = -1;
            end
        end
    end

    function automatic logic [W*DW-1:0] wd(input logic [7:0] c0, input logic [7:0] c1,
                                           input logic [7:0] c2);
        return {c2, c1, c0};
    endfunction

    task automatic put(input int k, input logic [W*DW-1:0] w);
        mem[k*W]     = w[7:0];
        mem[k*W + 1] = w[15:8];
        mem[k*W + 2] = w[23:16];
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 16; i++) mem[i] = 8'hAA;
    endtask

    // Issues one lookup; dcyc is the expected done cycle relative to the start cycle.
    task automatic run(input logic [W*DW-1:0] w, input logic f, input int idx, input int dcyc,
                       input int min_a, input int max_a, input bit poke);
        exp_t e;
        int   n;
        @(negedge clk);
        word    = w;
        start   = 1'b1;
        e.found = f;
        e.idx   = AW'(idx);
        e.cyc   = cyc + dcyc;
        e.min_a = min_a;
        e.max_a = max_a;
        sb.push_back(e);
        n = done_cnt;
        for (int c = 1; c <= dcyc + 2; c++) begin
            @(negedge clk);
            start = poke && (c == 3 || c == dcyc);
            if (start) word = wd("d", "o", "g");
        end
        start = 1'b0;
        chk("done_count", done_cnt - n, 1);
        chk("found_hold", int'(found), int'(f));
        chk("idle_after", int'(busy), 0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        word  = '0;
        clear_mem();
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_found", int'(found), 0);
        chk("rst_idx", int'(match_idx), 0);
        chk("rst_cs", int'(mem_cs), 0);
        chk("rst_addr", int'(mem_addr), 0);
        rst = 1'b0;

        // Match at entry 0.
        put(0, wd("c", "a", "t"));
        mem[3] = 8'h00;
        run(wd("c", "a", "t"), 1'b1, 0, 5, 2, 3, 1'b0);

        // Match at entry 2, with start pulses during scan and in DONE ignored.
        clear_mem();
        put(0, wd("d", "o", "g"));
        put(1, wd("c", "o", "w"));
        put(2, wd("c", "a", "t"));
        mem[9] = 8'h00;
        run(wd("c", "a", "t"), 1'b1, 6, 11, 8, 9, 1'b1);

        // End marker right after one entry.
        clear_mem();
        put(0, wd("d", "o", "g"));
        mem[3] = 8'h00;
        run(wd("c", "a", "t"), 1'b0, 0, 6, 3, 4, 1'b0);

        // Exhaustion, including a partial match "cab".
        clear_mem();
        put(0, wd("d", "o", "g"));
        put(1, wd("c", "o", "w"));
        put(2, wd("c", "a", "b"));
        put(3, wd("p", "i", "g"));
        put(4, wd("h", "e", "n"));
        run(wd("c", "a", "t"), 1'b0, 0, 17, 14, 14, 1'b0);

        // Match in the last usable entry.
        put(4, wd("c", "a", "t"));
        run(wd("c", "a", "t"), 1'b1, 12, 17, 14, 14, 1'b0);

        // Query containing a zero character, then a near miss ending at the marker.
        clear_mem();
        put(0, wd("d", "o", "g"));
        put(1, wd("c", 8'h00, "t"));
        mem[6] = 8'h00;
        run(wd("c", 8'h00, "t"), 1'b1, 3, 8, 5, 6, 1'b0);
        run(wd("c", "a", "t"), 1'b0, 0, 9, 6, 7, 1'b0);

        // Reset in cycle 4 of a scan.
        clear_mem();
        put(0, wd("d", "o", "g"));
        put(1, wd("c", "o", "w"));
        put(2, wd("c", "a", "t"));
        mem[9] = 8'h00;
        @(negedge clk);
        word  = wd("c", "a", "t");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_cs", int'(mem_cs), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_found", int'(found), 0);
        rst = 1'b0;
        begin
            int n0;
            n0 = done_cnt;
            repeat (12) @(negedge clk);
            chk("midrst_no_done", done_cnt - n0, 0);
        end
        run(wd("c", "a", "t"), 1'b1, 6, 11, 8, 9, 1'b0);

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
